id_ex_stage: RTL and testbench

// ID/EX pipeline register plus EX-side operand forwarding; sits directly upstream of the ALU.

---
 rtl/id_ex_stage_pkg.sv | 20 ++
 rtl/id_ex_stage_fwd_mux.sv | 41 ++++
 rtl/id_ex_stage.sv | 168 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg
// Shared widths and operand-B select codes for the ID/EX pipeline register
// and its forwarding muxes. Imported by id_ex_stage and fwd_mux.
package id_ex_stage_pkg;

    localparam int DATA_W  = 32;
    localparam int REG_AW  = 5;
    localparam int OP_W    = 6;
    localparam int SHAMT_W = 5;

    // Operand-B source; code 3 is a second encoding of "rt" so decode can
    // leave the field at either value for register-register instructions.
    typedef enum logic [1:0] {
        B_SEL_RT     = 2'd0,
        B_SEL_IMM    = 2'd1,
        B_SEL_SHAMT  = 2'd2,
        B_SEL_RT_ALT = 2'd3
    } b_sel_e;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// fwd_mux
// Resolves one EX source operand against the MEM and WB write ports.
// Ports:
//   idx          stored source register index of the EX instruction
//   stored_data  value captured from the register file at decode
//   reg_wr_mem / rd_addr_mem / res_mem   MEM-stage write port
//   reg_wr_wb  / rd_addr_wb  / res_wb    WB-stage write port
//   fwd_data     youngest value of register idx
module fwd_mux
    import id_ex_stage_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int AW = REG_AW
) (
    input  logic [AW-1:0] idx,
    input  logic [DW-1:0] stored_data,
    input  logic          reg_wr_mem,
    input  logic [AW-1:0] rd_addr_mem,
    input  logic [DW-1:0] res_mem,
    input  logic          reg_wr_wb,
    input  logic [AW-1:0] rd_addr_wb,
    input  logic [DW-1:0] res_wb,
    output logic [DW-1:0] fwd_data
);

    logic hit_mem;
    logic hit_wb;

    // MEM is younger than WB, so it wins; r0 is hardwired zero and never forwarded.
    always_comb begin
        hit_mem  = reg_wr_mem && (rd_addr_mem == idx) && (idx != '0);
        hit_wb   = reg_wr_wb  && (rd_addr_wb  == idx) && (idx != '0);
        fwd_data = stored_data;
        if (hit_mem) begin
            fwd_data = res_mem;
        end else if (hit_wb) begin
            fwd_data = res_wb;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage
// ID/EX pipeline register with EX-side operand forwarding, feeding the ALU.
// Detects load-use hazards and inserts a single-cycle bubble.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   *_id_i                      decoded instruction fields from ID
//   stall_ex_i                  downstream hold; EX contents are kept
//   flush_i                     squash the instruction on the ID inputs
//   reg_wr_mem_i/rd_addr_mem_i/res_mem_i   MEM forwarding source
//   reg_wr_wb_i/rd_addr_wb_i/res_wb_i      WB forwarding source
//   stall_id_o                  hold decode/fetch
//   valid_ex_o, opr_a_alu_o, opr_b_alu_o, op_alu_o, rd_addr_ex_o,
//   reg_wr_ex_o, mem_rd_ex_o    EX-stage outputs to the ALU and beyond
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DW  = DATA_W,
    parameter int AW  = REG_AW,
    parameter int OPW = OP_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid_id_i,
    input  logic [DW-1:0]      rs_data_id_i,
    input  logic [DW-1:0]      rt_data_id_i,
    input  logic [DW-1:0]      imm_id_i,
    input  logic [SHAMT_W-1:0] shamt_id_i,
    input  logic [AW-1:0]      rs_addr_id_i,
    input  logic [AW-1:0]      rt_addr_id_i,
    input  logic [AW-1:0]      rd_addr_id_i,
    input  logic [OPW-1:0]     alu_op_id_i,
    input  logic               a_sel_id_i,
    input  logic [1:0]         b_sel_id_i,
    input  logic               uses_rt_id_i,
    input  logic               reg_wr_id_i,
    input  logic               mem_rd_id_i,
    input  logic               stall_ex_i,
    input  logic               flush_i,
    input  logic               reg_wr_mem_i,
    input  logic [AW-1:0]      rd_addr_mem_i,
    input  logic [DW-1:0]      res_mem_i,
    input  logic               reg_wr_wb_i,
    input  logic [AW-1:0]      rd_addr_wb_i,
    input  logic [DW-1:0]      res_wb_i,
    output logic               stall_id_o,
    output logic               valid_ex_o,
    output logic [DW-1:0]      opr_a_alu_o,
    output logic [DW-1:0]      opr_b_alu_o,
    output logic [OPW-1:0]     op_alu_o,
    output logic [AW-1:0]      rd_addr_ex_o,
    output logic               reg_wr_ex_o,
    output logic               mem_rd_ex_o
);

    logic               valid_ex;
    logic [DW-1:0]      rs_data_ex;
    logic [DW-1:0]      rt_data_ex;
    logic [DW-1:0]      imm_ex;
    logic [SHAMT_W-1:0] shamt_ex;
    logic [AW-1:0]      rs_addr_ex;
    logic [AW-1:0]      rt_addr_ex;
    logic [AW-1:0]      rd_addr_ex;
    logic [OPW-1:0]     alu_op_ex;
    logic               a_sel_ex;
    b_sel_e             b_sel_ex;
    logic               reg_wr_ex;
    logic               mem_rd_ex;
    logic               flush_pend;

    logic [DW-1:0]      rs_fwd;
    logic [DW-1:0]      rt_fwd;
    logic               hz;

    fwd_mux #(.DW(DW), .AW(AW)) u_fwd_rs (
        .idx         (rs_addr_ex),
        .stored_data (rs_data_ex),
        .reg_wr_mem  (reg_wr_mem_i),
        .rd_addr_mem (rd_addr_mem_i),
        .res_mem     (res_mem_i),
        .reg_wr_wb   (reg_wr_wb_i),
        .rd_addr_wb  (rd_addr_wb_i),
        .res_wb      (res_wb_i),
        .fwd_data    (rs_fwd)
    );

    fwd_mux #(.DW(DW), .AW(AW)) u_fwd_rt (
        .idx         (rt_addr_ex),
        .stored_data (rt_data_ex),
        .reg_wr_mem  (reg_wr_mem_i),
        .rd_addr_mem (rd_addr_mem_i),
        .res_mem     (res_mem_i),
        .reg_wr_wb   (reg_wr_wb_i),
        .rd_addr_wb  (rd_addr_wb_i),
        .res_wb      (res_wb_i),
        .fwd_data    (rt_fwd)
    );

    // A load in EX cannot forward its data to the instruction in ID in time,
    // so that consumer must wait one cycle.
    always_comb begin
        hz = valid_ex && mem_rd_ex && (rd_addr_ex != '0) && valid_id_i &&
             ((rd_addr_ex == rs_addr_id_i) ||
              (uses_rt_id_i && (rd_addr_ex == rt_addr_id_i)));
        stall_id_o = hz || stall_ex_i;
    end

    // While held, the stored operands are overwritten with their forwarded
    // values so a producer retiring out of MEM/WB does not lose the result.
    // A flush that arrives during a hold is remembered and applied to the
    // next accepted instruction, which is the one it targeted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_ex   <= 1'b0;
            rs_data_ex <= '0;
            rt_data_ex <= '0;
            imm_ex     <= '0;
            shamt_ex   <= '0;
            rs_addr_ex <= '0;
            rt_addr_ex <= '0;
            rd_addr_ex <= '0;
            alu_op_ex  <= '0;
            a_sel_ex   <= 1'b0;
            b_sel_ex   <= B_SEL_RT;
            reg_wr_ex  <= 1'b0;
            mem_rd_ex  <= 1'b0;
            flush_pend <= 1'b0;
        end else if (stall_ex_i) begin
            rs_data_ex <= rs_fwd;
            rt_data_ex <= rt_fwd;
            if (flush_i) begin
                flush_pend <= 1'b1;
            end
        end else if (hz) begin
            valid_ex <= 1'b0;
        end else begin
            valid_ex   <= valid_id_i && !flush_i && !flush_pend;
            rs_data_ex <= rs_data_id_i;
            rt_data_ex <= rt_data_id_i;
            imm_ex     <= imm_id_i;
            shamt_ex   <= shamt_id_i;
            rs_addr_ex <= rs_addr_id_i;
            rt_addr_ex <= rt_addr_id_i;
            rd_addr_ex <= rd_addr_id_i;
            alu_op_ex  <= alu_op_id_i;
            a_sel_ex   <= a_sel_id_i;
            b_sel_ex   <= b_sel_e'(b_sel_id_i);
            reg_wr_ex  <= reg_wr_id_i;
            mem_rd_ex  <= mem_rd_id_i;
            flush_pend <= 1'b0;
        end
    end

    // Operand A takes rt for shifts; immediates and shamt bypass forwarding.
    always_comb begin
        opr_a_alu_o = a_sel_ex ? rt_fwd : rs_fwd;
        case (b_sel_ex)
            B_SEL_IMM:   opr_b_alu_o = imm_ex;
            B_SEL_SHAMT: opr_b_alu_o = {{(DW-SHAMT_W){1'b0}}, shamt_ex};
            default:     opr_b_alu_o = rt_fwd;
        endcase
        valid_ex_o   = valid_ex;
        op_alu_o     = alu_op_ex;
        rd_addr_ex_o = rd_addr_ex;
        reg_wr_ex_o  = reg_wr_ex && valid_ex;
        mem_rd_ex_o  = mem_rd_ex && valid_ex;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage
// Directed self-checking bench for id_ex_stage: forwarding priority, r0,
// operand-B selection, load-use bubble, stall refresh, flush during stall
// and reset during stall.
module tb_id_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        valid_id_i;
    logic [31:0] rs_data_id_i;
    logic [31:0] rt_data_id_i;
    logic [31:0] imm_id_i;
    logic [4:0]  shamt_id_i;
    logic [4:0]  rs_addr_id_i;
    logic [4:0]  rt_addr_id_i;
    logic [4:0]  rd_addr_id_i;
    logic [5:0]  alu_op_id_i;
    logic        a_sel_id_i;
    logic [1:0]  b_sel_id_i;
    logic        uses_rt_id_i;
    logic        reg_wr_id_i;
    logic        mem_rd_id_i;
    logic        stall_ex_i;
    logic        flush_i;
    logic        reg_wr_mem_i;
    logic [4:0]  rd_addr_mem_i;
    logic [31:0] res_mem_i;
    logic        reg_wr_wb_i;
    logic [4:0]  rd_addr_wb_i;
    logic [31:0] res_wb_i;
    logic        stall_id_o;
    logic        valid_ex_o;
    logic [31:0] opr_a_alu_o;
    logic [31:0] opr_b_alu_o;
    logic [5:0]  op_alu_o;
    logic [4:0]  rd_addr_ex_o;
    logic        reg_wr_ex_o;
    logic        mem_rd_ex_o;

    int tests_run    = 0;
    int tests_failed = 0;

    id_ex_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .valid_id_i    (valid_id_i),
        .rs_data_id_i  (rs_data_id_i),
        .rt_data_id_i  (rt_data_id_i),
        .imm_id_i      (imm_id_i),
        .shamt_id_i    (shamt_id_i),
        .rs_addr_id_i  (rs_addr_id_i),
        .rt_addr_id_i  (rt_addr_id_i),
        .rd_addr_id_i  (rd_addr_id_i),
        .alu_op_id_i   (alu_op_id_i),
        .a_sel_id_i    (a_sel_id_i),
        .b_sel_id_i    (b_sel_id_i),
        .uses_rt_id_i  (uses_rt_id_i),
        .reg_wr_id_i   (reg_wr_id_i),
        .mem_rd_id_i   (mem_rd_id_i),
        .stall_ex_i    (stall_ex_i),
        .flush_i       (flush_i),
        .reg_wr_mem_i  (reg_wr_mem_i),
        .rd_addr_mem_i (rd_addr_mem_i),
        .res_mem_i     (res_mem_i),
        .reg_wr_wb_i   (reg_wr_wb_i),
        .rd_addr_wb_i  (rd_addr_wb_i),
        .res_wb_i      (res_wb_i),
        .stall_id_o    (stall_id_o),
        .valid_ex_o    (valid_ex_o),
        .opr_a_alu_o   (opr_a_alu_o),
        .opr_b_alu_o   (opr_b_alu_o),
        .op_alu_o      (op_alu_o),
        .rd_addr_ex_o  (rd_addr_ex_o),
        .reg_wr_ex_o   (reg_wr_ex_o),
        .mem_rd_ex_o   (mem_rd_ex_o)
    );

    // Free-running clock, posedge at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Presents a valid decoded instruction on the ID inputs.
    task automatic apply_stimulus(input logic [31:0] rs_d, input logic [31:0] rt_d,
                                  input logic [31:0] imm, input logic [4:0] shamt,
                                  input logic [4:0] rs, input logic [4:0] rt,
                                  input logic [4:0] rd, input logic [5:0] op,
                                  input logic a_sel, input logic [1:0] b_sel,
                                  input logic uses_rt, input logic reg_wr,
                                  input logic mem_rd);
        valid_id_i   = 1'b1;
        rs_data_id_i = rs_d;
        rt_data_id_i = rt_d;
        imm_id_i     = imm;
        shamt_id_i   = shamt;
        rs_addr_id_i = rs;
        rt_addr_id_i = rt;
        rd_addr_id_i = rd;
        alu_op_id_i  = op;
        a_sel_id_i   = a_sel;
        b_sel_id_i   = b_sel;
        uses_rt_id_i = uses_rt;
        reg_wr_id_i  = reg_wr;
        mem_rd_id_i  = mem_rd;
    endtask

    task automatic set_mem(input logic wr, input logic [4:0] addr, input logic [31:0] data);
        reg_wr_mem_i  = wr;
        rd_addr_mem_i = addr;
        res_mem_i     = data;
    endtask

    task automatic set_wb(input logic wr, input logic [4:0] addr, input logic [31:0] data);
        reg_wr_wb_i  = wr;
        rd_addr_wb_i = addr;
        res_wb_i     = data;
    endtask

    initial begin
        rst_n      = 1'b0;
        stall_ex_i = 1'b0;
        flush_i    = 1'b0;
        apply_stimulus(32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        valid_id_i = 1'b0;
        set_mem(1'b0, 5'd0, 32'h0);
        set_wb(1'b0, 5'd0, 32'h0);
        tick();
        tick();
        check_output("reset_valid", {31'b0, valid_ex_o}, 32'h0);
        check_output("reset_opr_a", opr_a_alu_o, 32'h0);
        check_output("reset_opr_b", opr_b_alu_o, 32'h0);
        check_output("reset_stall_id", {31'b0, stall_id_o}, 32'h0);
        rst_n = 1'b1;

        // add-like: rs=r3, rt=r4, rd=r8
        apply_stimulus(32'hAAAA, 32'hBBBB, 32'h0, 5'd0, 5'd3, 5'd4, 5'd8, 6'h21, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
        tick();
        check_output("issue_valid", {31'b0, valid_ex_o}, 32'h1);
        check_output("issue_op", {26'b0, op_alu_o}, 32'h21);
        check_output("issue_rd", {27'b0, rd_addr_ex_o}, 32'd8);
        check_output("issue_reg_wr", {31'b0, reg_wr_ex_o}, 32'h1);
        check_output("nofwd_a", opr_a_alu_o, 32'hAAAA);
        check_output("nofwd_b", opr_b_alu_o, 32'hBBBB);
        set_mem(1'b1, 5'd3, 32'h11);
        set_wb(1'b1, 5'd3, 32'h22);
        #1;
        check_output("mem_beats_wb_a", opr_a_alu_o, 32'h11);
        set_mem(1'b1, 5'd4, 32'h44);
        #1;
        check_output("wb_fwd_a", opr_a_alu_o, 32'h22);
        check_output("mem_fwd_b", opr_b_alu_o, 32'h44);
        set_mem(1'b0, 5'd0, 32'h0);
        set_wb(1'b0, 5'd0, 32'h0);

        // r0 sources with immediate operand B
        apply_stimulus(32'h77, 32'h66, 32'h1234, 5'd0, 5'd0, 5'd0, 5'd9, 6'h08, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0);
        tick();
        set_mem(1'b1, 5'd0, 32'h55);
        set_wb(1'b1, 5'd0, 32'h56);
        #1;
        check_output("r0_nofwd_a", opr_a_alu_o, 32'h77);
        check_output("imm_b", opr_b_alu_o, 32'h1234);
        set_mem(1'b0, 5'd0, 32'h0);
        set_wb(1'b0, 5'd0, 32'h0);

        // shift: A = forwarded rt, B = shamt (never forwarded)
        apply_stimulus(32'h10, 32'h5, 32'hFFFF, 5'd4, 5'd2, 5'd9, 5'd10, 6'h00, 1'b1, 2'd2, 1'b1, 1'b1, 1'b0);
        tick();
        set_mem(1'b1, 5'd9, 32'hF0);
        #1;
        check_output("shift_a_rt_fwd", opr_a_alu_o, 32'hF0);
        check_output("shamt_b", opr_b_alu_o, 32'h4);
        set_mem(1'b0, 5'd0, 32'h0);

        // load-use: lw r5 in EX, add rs=r5 in ID
        apply_stimulus(32'h100, 32'h0, 32'h4, 5'd0, 5'd1, 5'd5, 5'd5, 6'h23, 1'b0, 2'd1, 1'b0, 1'b1, 1'b1);
        tick();
        check_output("lw_mem_rd", {31'b0, mem_rd_ex_o}, 32'h1);
        apply_stimulus(32'hDEAD, 32'h3, 32'h0, 5'd0, 5'd5, 5'd6, 5'd10, 6'h20, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
        #1;
        check_output("lu_stall_id", {31'b0, stall_id_o}, 32'h1);
        tick();
        check_output("lu_bubble_valid", {31'b0, valid_ex_o}, 32'h0);
        check_output("lu_bubble_reg_wr", {31'b0, reg_wr_ex_o}, 32'h0);
        check_output("lu_bubble_mem_rd", {31'b0, mem_rd_ex_o}, 32'h0);
        check_output("lu_stall_cleared", {31'b0, stall_id_o}, 32'h0);
        tick();
        set_mem(1'b1, 5'd5, 32'h1000);
        #1;
        check_output("lu_add_valid", {31'b0, valid_ex_o}, 32'h1);
        check_output("lu_add_fwd_a", opr_a_alu_o, 32'h1000);
        check_output("lu_add_b", opr_b_alu_o, 32'h3);
        set_mem(1'b0, 5'd0, 32'h0);

        // stall refresh: rt=r7 held for 3 cycles while the producer drains
        apply_stimulus(32'h1, 32'h2, 32'h0, 5'd0, 5'd2, 5'd7, 5'd11, 6'h20, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
        tick();
        apply_stimulus(32'h0, 32'hEE, 32'h0, 5'd0, 5'd1, 5'd1, 5'd12, 6'h20, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
        stall_ex_i = 1'b1;
        set_mem(1'b1, 5'd7, 32'h9);
        #1;
        check_output("sr_mem_b", opr_b_alu_o, 32'h9);
        check_output("sr_stall_id", {31'b0, stall_id_o}, 32'h1);
        tick();
        set_mem(1'b1, 5'd12, 32'h33);
        set_wb(1'b1, 5'd7, 32'h9);
        #1;
        check_output("sr_wb_b", opr_b_alu_o, 32'h9);
        tick();
        set_mem(1'b0, 5'd0, 32'h0);
        set_wb(1'b0, 5'd0, 32'h0);
        #1;
        check_output("sr_retired_b", opr_b_alu_o, 32'h9);
        check_output("sr_hold_rd", {27'b0, rd_addr_ex_o}, 32'd11);
        tick();
        stall_ex_i = 1'b0;
        #1;
        check_output("sr_release_b", opr_b_alu_o, 32'h9);
        check_output("sr_release_valid", {31'b0, valid_ex_o}, 32'h1);

        // flush during stall squashes the next accepted instruction only
        apply_stimulus(32'h0, 32'h0, 32'h0, 5'd0, 5'd1, 5'd1, 5'd13, 6'h20, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
        stall_ex_i = 1'b1;
        flush_i    = 1'b1;
        tick();
        stall_ex_i = 1'b0;
        flush_i    = 1'b0;
        apply_stimulus(32'h0, 32'h0, 32'h0, 5'd0, 5'd1, 5'd1, 5'd14, 6'h20, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
        tick();
        check_output("fl_squash_valid", {31'b0, valid_ex_o}, 32'h0);
        check_output("fl_squash_reg_wr", {31'b0, reg_wr_ex_o}, 32'h0);
        apply_stimulus(32'h0, 32'h0, 32'h0, 5'd0, 5'd1, 5'd1, 5'd15, 6'h20, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
        tick();
        check_output("fl_next_valid", {31'b0, valid_ex_o}, 32'h1);
        check_output("fl_next_rd", {27'b0, rd_addr_ex_o}, 32'd15);
        check_output("fl_next_reg_wr", {31'b0, reg_wr_ex_o}, 32'h1);

        // reset while stalled
        stall_ex_i = 1'b1;
        set_mem(1'b1, 5'd1, 32'hABC);
        rst_n = 1'b0;
        tick();
        stall_ex_i = 1'b0;
        valid_id_i = 1'b0;
        #1;
        check_output("rst_valid", {31'b0, valid_ex_o}, 32'h0);
        check_output("rst_opr_a", opr_a_alu_o, 32'h0);
        check_output("rst_opr_b", opr_b_alu_o, 32'h0);
        check_output("rst_op", {26'b0, op_alu_o}, 32'h0);
        check_output("rst_rd", {27'b0, rd_addr_ex_o}, 32'h0);
        check_output("rst_reg_wr", {31'b0, reg_wr_ex_o}, 32'h0);
        check_output("rst_mem_rd", {31'b0, mem_rd_ex_o}, 32'h0);
        check_output("rst_stall_id", {31'b0, stall_id_o}, 32'h0);
        rst_n = 1'b1;
        set_mem(1'b0, 5'd0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
